// File: rtl/red_pitaya_mux_sequencer.sv
// red_pitaya_mux_sequencer: steps the analog mux address through the active channels
// with programmable settle/dwell windows, stable flag, sample strobes and sweep completion.
module red_pitaya_mux_sequencer #(
  parameter int CHNL = 8,
  parameter int MAW  = 3,
  parameter int CW   = 16
) (
  input  logic            adc_clk_i,
  input  logic            adc_rstn_i,
  input  logic            enable_i,
  input  logic [1:0]      mode_i,
  input  logic [CHNL-1:0] active_channels_i,
  input  logic [MAW-1:0]  fixed_addr_i,
  input  logic [CW-1:0]   settle_i,
  input  logic [CW-1:0]   dwell_i,
  input  logic            start_i,
  output logic [MAW-1:0]  mux_addr_o,
  output logic            signal_stable_o,
  output logic            sample_valid_o,
  output logic            sweep_done_o,
  output logic            busy_o
);
  localparam logic [1:0] IDLE = 2'd0, SETTLE = 2'd1, DWELL = 2'd2;
  logic [1:0]     state, nstate;
  logic [CW-1:0]  cnt, ncnt, settle_ld, dwell_ld;
  logic [MAW-1:0] naddr, tgt, low_act, up_act;
  logic           has_act, has_up, fix_ok, go, ndone;
  assign settle_ld = (settle_i == '0) ? CW'(1) : settle_i;
  assign dwell_ld  = (dwell_i == '0) ? CW'(1) : dwell_i;
  assign fix_ok    = 32'(fixed_addr_i) < CHNL;
  assign busy_o    = state != IDLE;
  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    low_act = '0;
    has_act = 1'b0;
    up_act  = '0;
    has_up  = 1'b0;
    for (int i = CHNL - 1; i >= 0; i--)
      if (active_channels_i[i]) begin
        low_act = MAW'(i);
        has_act = 1'b1;
        if (i > int'(mux_addr_o)) begin
          up_act = MAW'(i);
          has_up = 1'b1;
        end
      end
  end
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    naddr  = mux_addr_o;
    ndone  = 1'b0;
    go     = 1'b0;
    tgt    = mux_addr_o;
    if (!enable_i)
      nstate = IDLE;
    else if (state == IDLE) begin
      go     = (mode_i == 2'd1) ? fix_ok : has_act && (mode_i != 2'd2 || start_i);
      tgt    = (mode_i == 2'd1) ? fixed_addr_i : low_act;
      nstate = go ? SETTLE : IDLE;
      naddr  = go ? tgt : mux_addr_o;
      ncnt   = go ? settle_ld : '0;
    end else if (cnt > CW'(1))
      ncnt = cnt - CW'(1);
    else if (state == SETTLE) begin
      nstate = DWELL;
      ncnt   = dwell_ld;
    end else begin
      go     = (mode_i == 2'd1) ? fix_ok : (mode_i == 2'd2) ? has_up : has_act;
      tgt    = (mode_i == 2'd1) ? fixed_addr_i : has_up ? up_act : low_act;
      ndone  = mode_i == 2'd2 && has_act && !has_up;
      nstate = !go ? IDLE : (tgt == mux_addr_o) ? DWELL : SETTLE;
      naddr  = go ? tgt : mux_addr_o;
      ncnt   = !go ? '0 : (tgt == mux_addr_o) ? dwell_ld : settle_ld;
    end
  end
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i)
    if (!adc_rstn_i) begin
      state           <= IDLE;
      cnt             <= '0;
      mux_addr_o      <= '0;
      signal_stable_o <= 1'b0;
      sample_valid_o  <= 1'b0;
      sweep_done_o    <= 1'b0;
    end else begin
      state           <= nstate;
      cnt             <= ncnt;
      mux_addr_o      <= naddr;
      signal_stable_o <= nstate == DWELL;
      sample_valid_o  <= nstate == DWELL && ncnt == CW'(1);
      sweep_done_o    <= ndone;
    end
endmodule

// File: tb/tb_red_pitaya_mux_sequencer.sv
// tb_red_pitaya_mux_sequencer: scoreboard bench; expected sample/sweep events are derived
// from channel lists and window lengths, and a monitor matches them against DUT strobes.
module tb_red_pitaya_mux_sequencer;
  localparam int CHNL = 8, MAW = 4, CW = 16;
  logic            clk = 1'b0, rst_n = 1'b0;
  logic            enable = 1'b0, start = 1'b0;
  logic [1:0]      mode = '0;
  logic [CHNL-1:0] active = '0;
  logic [MAW-1:0]  fixed = '0;
  logic [CW-1:0]   settle = '0, dwell = '0;
  logic [MAW-1:0]  mux_addr;
  logic            stable, sample_valid, sweep_done, busy;
  int              cyc = 0, passed = 0, total = 0;
  typedef struct { int kind; int addr; int stamp; } ev_t;
  ev_t q[$];

  red_pitaya_mux_sequencer #(.CHNL(CHNL), .MAW(MAW), .CW(CW)) dut (
    .adc_clk_i(clk), .adc_rstn_i(rst_n), .enable_i(enable), .mode_i(mode),
    .active_channels_i(active), .fixed_addr_i(fixed), .settle_i(settle), .dwell_i(dwell),
    .start_i(start), .mux_addr_o(mux_addr), .signal_stable_o(stable),
    .sample_valid_o(sample_valid), .sweep_done_o(sweep_done), .busy_o(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int got, int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(int kind, int addr, int stamp);
    ev_t e;
    e.kind = kind; e.addr = addr; e.stamp = stamp;
    q.push_back(e);
  endtask

  task automatic on_event(int kind);
    ev_t e;
    if (q.size() == 0) begin
      chk(kind ? "unexpected sweep_done" : "unexpected sample_valid", 1, 0);
      return;
    end
    e = q.pop_front();
    chk("event kind", kind, e.kind);
    chk("event addr", int'(mux_addr), e.addr);
    chk("event cycle", cyc, e.stamp);
  endtask

  always @(negedge clk)
    if (rst_n) begin
      if (sample_valid) begin
        chk("stable during sample", int'(stable), 1);
        on_event(0);
      end
      if (sweep_done) on_event(1);
    end

  // Event k is produced by the k-th edge after enabling; the enable window covers edges 0..l-1.
  task automatic push_model(int base, int md, logic [7:0] act, int fix, int s, int d, int l);
    int ch[$];
    int se, de, k, n;
    se = (s == 0) ? 1 : s;
    de = (d == 0) ? 1 : d;
    for (int i = 0; i < CHNL; i++) if (act[i]) ch.push_back(i);
    n = ch.size();
    if (md == 1) begin
      if (fix < CHNL)
        for (k = se + de - 1; k < l; k += de) push(0, fix, base + 1 + k);
    end else if (md == 2) begin
      if (n > 0) begin
        for (int i = 0; i < n; i++) begin
          k = se + de - 1 + i * (se + de);
          if (k < l) push(0, ch[i], base + 1 + k);
        end
        k = n * (se + de);
        if (k < l) push(1, ch[n-1], base + 1 + k);
      end
    end else if (n > 0) begin
      int i = 0;
      for (k = se + de - 1; k < l; k += (n == 1) ? de : se + de) begin
        push(0, ch[i % n], base + 1 + k);
        i++;
      end
    end
  endtask

  task automatic run_seg(int md, logic [7:0] act, int fix, int s, int d, int l);
    mode = 2'(md); active = act; fixed = MAW'(fix); settle = CW'(s); dwell = CW'(d);
    push_model(cyc, md, act, fix, s, d, l);
    enable = 1'b1;
    start = (md == 2);
    tick(1);
    start = 1'b0;
    if (l > 1) tick(l - 1);
    enable = 1'b0;
    tick(1);
    chk("busy after disable", int'(busy), 0);
    chk("stable after disable", int'(stable), 0);
    tick(3);
    chk("missing events", q.size(), 0);
    q.delete();
  endtask

  initial begin
    tick(2);
    chk("reset addr", int'(mux_addr), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset stable", int'(stable), 0);
    chk("reset sample_valid", int'(sample_valid), 0);
    chk("reset sweep_done", int'(sweep_done), 0);
    rst_n = 1'b1;
    tick(2);
    run_seg(0, 8'b0010_0101, 0, 3, 5, 40);
    run_seg(2, 8'b1000_0010, 0, 2, 3, 30);
    chk("sweep holds addr", int'(mux_addr), 7);
    run_seg(0, 8'h00, 0, 0, 0, 10);
    run_seg(0, 8'h81, 0, 0, 0, 20);
    run_seg(3, 8'b0100_1000, 0, 1, 2, 25);
    run_seg(1, 8'h00, 9, 1, 1, 10);
    // single-channel scan keeps the window open without settling
    mode = 2'd0; active = 8'h08; settle = 16'd2; dwell = 16'd4;
    push(0, 3, cyc + 6); push(0, 3, cyc + 10); push(0, 3, cyc + 14);
    enable = 1'b1;
    tick(3);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("single stable", int'(stable), 1);
      chk("single addr", int'(mux_addr), 3);
    end
    tick(2);
    enable = 1'b0;
    tick(4);
    chk("single missing", q.size(), 0);
    // fixed address change only lands at the end of the dwell window
    mode = 2'd1; fixed = 4'd4; settle = 16'd2; dwell = 16'd3;
    push(0, 4, cyc + 5); push(0, 4, cyc + 8); push(0, 6, cyc + 13);
    enable = 1'b1;
    tick(6);
    fixed = 4'd6;
    tick(1);
    chk("fixed held mid-dwell", int'(mux_addr), 4);
    tick(6);
    fixed = 4'd9;
    tick(2);
    chk("fixed invalid busy", int'(busy), 0);
    chk("fixed invalid addr", int'(mux_addr), 6);
    enable = 1'b0;
    tick(2);
    chk("fixed missing", q.size(), 0);
    // asynchronous reset in the middle of settling
    mode = 2'd0; active = 8'b0010_0000; settle = 16'd4; dwell = 16'd2;
    enable = 1'b1;
    tick(2);
    chk("settle addr", int'(mux_addr), 5);
    chk("settle busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async addr", int'(mux_addr), 0);
    chk("async busy", int'(busy), 0);
    chk("async stable", int'(stable), 0);
    enable = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick(2);
    run_seg(0, 8'h08, 0, 1, 4, 3);
    for (int n = 0; n < 30; n++) begin
      int md, sel;
      logic [7:0] act;
      md = $urandom_range(0, 3);
      sel = $urandom_range(0, 5);
      act = (sel == 0) ? 8'h00 : (sel == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom);
      run_seg(md, act, $urandom_range(0, 9), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(5, 60));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
